fsm_decode_ds: RTL and testbench

FSM_DECODE_DS -- requirements
Module: fsm_decode_ds

---
 rtl/fsm_decode_ds.sv | 103 ++++++++++
 tb/tb_fsm_decode_ds.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_decode_ds.sv
// Two-byte frame decoder: recovers operands A and B from a stored result/key pair.
// Six-state FSM; the ADD/SUB pair restores reg1 so out_a is the shifted byte 1.
module fsm_decode_ds (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] out_a,
    output logic [7:0] out_b,
    output logic       out_valid,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT2 = 3'd1,
        SHR   = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] reg1;
    logic [7:0] reg2;
    logic       err_next;
    logic       accept;
    logic [7:0] sub_res;

    assign accept  = in_valid && in_ready;
    assign sub_res = reg1 - reg2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = WAIT2;
            WAIT2:   if (accept) state_nxt = SHR;
            SHR:     state_nxt = ADD;
            ADD:     state_nxt = SUB;
            SUB:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) || (state == WAIT2);
        busy     = (state != IDLE);
    end

    // Datapath: the out_* registers load on the SUB->DONE edge only.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg1      <= 8'h00;
            reg2      <= 8'h00;
            err_next  <= 1'b0;
            out_a     <= 8'h00;
            out_b     <= 8'h00;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) reg1 <= in_data;
                end
                WAIT2: begin
                    if (accept) reg2 <= in_data;
                end
                SHR: begin
                    reg1     <= {1'b0, reg1[7:1]};
                    err_next <= reg1[0];
                end
                ADD: begin
                    reg1 <= reg1 + reg2;
                end
                SUB: begin
                    reg1      <= sub_res;
                    out_a     <= sub_res;
                    out_b     <= reg2;
                    err       <= err_next;
                    out_valid <= 1'b1;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_decode_ds.sv
// Scoreboard bench for fsm_decode_ds: a cycle model predicts handshakes,
// expected frames are queued on byte-2 accept and popped on out_valid.
module tb_fsm_decode_ds;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       out_valid;
    logic       err;
    logic       busy;

    fsm_decode_ds dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_valid(out_valid),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       e;
    } frm_t;

    frm_t        sb[$];
    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          m_ph = 0;
    logic [7:0]  m_b1 = 8'h00;
    logic [7:0]  h_a = 8'h00;
    logic [7:0]  h_b = 8'h00;
    logic        h_e = 1'b0;
    int          n_pulse = 0;
    int          lo_cnt = 0;
    int          p_t[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference phase model: 0 IDLE, 1 WAIT2, 2..4 compute, 5 DONE.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_ph <= 0;
            m_b1 <= 8'h00;
            sb.delete();
        end else begin
            case (m_ph)
                0: if (in_valid) begin
                    m_b1 <= in_data;
                    m_ph <= 1;
                end
                1: if (in_valid) begin
                    sb.push_back({m_b1 >> 1, in_data, m_b1[0]});
                    m_ph <= 2;
                end
                5: m_ph <= 0;
                default: m_ph <= m_ph + 1;
            endcase
        end
    end

    always @(negedge clk) begin
        frm_t e;
        chk("in_ready", in_ready, m_ph < 2);
        chk("busy", busy, m_ph != 0);
        chk("out_valid", out_valid, m_ph == 5);
        if (!in_ready) lo_cnt <= lo_cnt + 1;
        if (out_valid) begin
            n_pulse <= n_pulse + 1;
            p_t.push_back(cyc);
        end
        if (rst) begin
            h_a <= 8'h00;
            h_b <= 8'h00;
            h_e <= 1'b0;
        end
        if (m_ph == 5) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_a", out_a, e.a);
                chk("out_b", out_b, e.b);
                chk("err", err, e.e);
                h_a <= e.a;
                h_b <= e.b;
                h_e <= e.e;
            end
        end else if (!rst) begin
            chk("hold_a", out_a, h_a);
            chk("hold_b", out_b, h_b);
            chk("hold_e", err, h_e);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a byte and return just after the edge that accepts it.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (m_ph >= 2 && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        tick(1);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (m_ph != 5 && n < 20) begin
            tick(1);
            n++;
        end
        chk("pulse_wait", n < 20, 1);
    endtask

    initial begin
        int base;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick(2);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_a", out_a, 0);
        chk("rst_valid", out_valid, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick(2);

        send(8'h54);
        send(8'h17);
        in_valid = 1'b0;
        wait_out();
        tick(1);
        chk("basic_a", out_a, 8'h2A);
        chk("basic_b", out_b, 8'h17);
        chk("basic_e", err, 0);
        tick(2);

        send(8'h55);
        send(8'h01);
        in_valid = 1'b0;
        wait_out();
        tick(1);
        chk("odd_a", out_a, 8'h2A);
        chk("odd_e", err, 1);
        send(8'h20);
        send(8'h05);
        in_valid = 1'b0;
        wait_out();
        tick(1);
        chk("clr_e", err, 0);
        chk("clr_a", out_a, 8'h10);

        send(8'hFE);
        send(8'hF0);
        in_valid = 1'b0;
        wait_out();
        tick(1);
        chk("wrap_a", out_a, 8'h7F);
        chk("wrap_b", out_b, 8'hF0);
        tick(2);

        base = n_pulse;
        lo_cnt = 0;
        send(8'h81);
        in_valid = 1'b0;
        tick(5);
        send(8'h3C);
        in_data = 8'hAA;
        tick(4);
        in_valid = 1'b0;
        tick(4);
        chk("gap_pulses", n_pulse - base, 1);
        chk("gap_lo", lo_cnt, 4);
        chk("gap_ph", m_ph, 0);

        base = n_pulse;
        send(8'h12); send(8'h34);
        send(8'hC7); send(8'h9B);
        send(8'hFF); send(8'hFF);
        in_valid = 1'b0;
        tick(8);
        chk("b2b_pulses", n_pulse - base, 3);
        if (p_t.size() >= 3) begin
            chk("b2b_gap1", p_t[p_t.size()-2] - p_t[p_t.size()-3], 6);
            chk("b2b_gap2", p_t[p_t.size()-1] - p_t[p_t.size()-2], 6);
        end else begin
            chk("b2b_times", p_t.size(), 3);
        end

        base = n_pulse;
        send(8'h33);
        send(8'h44);
        in_valid = 1'b0;
        tick(1);
        chk("mid_ph", m_ph, 3);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick(1);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick(6);
        chk("mid_pulses", n_pulse - base, 0);
        chk("mid_a", out_a, 0);
        chk("mid_b", out_b, 0);
        chk("mid_e", err, 0);
        send(8'h10);
        send(8'h02);
        in_valid = 1'b0;
        wait_out();
        tick(1);
        chk("post_a", out_a, 8'h08);
        chk("post_b", out_b, 8'h02);
        tick(4);
        chk("sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
